data_ram_responder: RTL
=======================

# data_ram_responder

Word-addressed data RAM that sits on the slave side of the CPU's RAM port (CE/RD/WR/ADDR/DATA) and answers every load, store and atomic-swap request the core issues. It latches a request, inserts a programmable number of wait states, performs the access, and returns a one-cycle ready pulse with read data or an error flag. It replaces the zero-latency array model in the SoC so cores and benches can be exercised against a memory with real latency.

## Interface
- DEPTH, 64: number of 32-bit words; legal word index 0..DEPTH-1 (DEPTH ≤ 64).
- WAIT_CYCLES, 1: wait states inserted between acceptance and access (0..15).

- iCLK  in  1  clock, all state changes on rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iRAM_CE  in  1  chip enable / request valid.
- iRAM_RD  in  1  read request.
- iRAM_WR  in  1  write request; RD and WR both high = atomic swap.
- iRAM_ADDR  in  8  byte address; word index = ADDR[7:2].
- iRAM_DATA  in  32  write data.
- oRAM_DATA  out  32  read data, valid while oRAM_READY=1.
- oRAM_READY  out  1  one-cycle completion pulse.
- oRAM_ERR  out  1  error flag, valid with oRAM_READY.
- oRAM_BUSY  out  1  high whenever FSM is not IDLE.
- iDBG_ADDR  in  6  debug word index.
- oDBG_DATA  out  32  combinational mem[iDBG_ADDR] (0 if out of range).

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE: request = CE & (RD|WR). On request latch ADDR, DATA, RD, WR; go WAIT (cnt=0) if WAIT_CYCLES>0, else ACCESS. CE with RD=WR=0 ignored.
- WAIT: cnt increments each cycle; at cnt==WAIT_CYCLES-1 go ACCESS. Input changes ignored (latched request completes even if CE drops).
- ACCESS: error check, then op on latched values; go DONE.
  - Error if ADDR[1:0]≠0 or ADDR[7:2]≥DEPTH: no write, oRAM_DATA←0, oRAM_ERR←1.
  - Read: oRAM_DATA←mem[idx].
  - Write: mem[idx]←data; oRAM_DATA←0.
  - Swap: oRAM_DATA←old mem[idx] and mem[idx]←data in the same edge.
  - oRAM_READY←1.
- DONE: oRAM_READY held 1 for exactly this cycle; next edge clears READY, ERR, DATA→0, go IDLE.
- Initiator must drop CE (or present the next request) in the cycle it sees READY; CE held high in IDLE is a new request.
- Memory array not cleared by reset; simulation initial contents zero.

## Timing
- Reset values: oRAM_DATA=0, oRAM_READY=0, oRAM_ERR=0, oRAM_BUSY=0, state IDLE, cnt=0.
- Accept on edge E0; READY high in the cycle after edge E0+WAIT_CYCLES+1 (WAIT_CYCLES=0: after E0+1; default 1: after E0+2).
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles (IDLE, WAIT×N, ACCESS, DONE).
- oRAM_BUSY rises the cycle after acceptance, falls on the edge leaving DONE.
- Write visible on oDBG_DATA from the edge leaving ACCESS.
- Reset mid-operation: immediate return to IDLE, all outputs 0; write aborted unless its ACCESS edge already occurred.
- Reset during DONE: READY drops immediately (async).
- Address wrap: no wrap; idx ≥ DEPTH is an error, never aliased.

## Test plan
- Reset, WAIT_CYCLES=1: write 0xDEADBEEF to ADDR 0x10 -> READY one cycle 3 edges after accept, ERR=0, oDBG_DATA[4]=0xDEADBEEF; read 0x10 -> oRAM_DATA=0xDEADBEEF with READY.
- Swap: mem[2]=0x11112222, RD=WR=1, ADDR 0x08, DATA 0x33334444 -> oRAM_DATA=0x11112222, then mem[2]=0x33334444.
- Misaligned write ADDR 0x05 and out-of-range ADDR 0xFC with DEPTH=32 -> READY with ERR=1, oRAM_DATA=0, memory unchanged.
- WAIT_CYCLES=0 and 3: count cycles accept→READY = 2 and 5 edges; CE dropped during WAIT still completes.
- iRST pulsed during WAIT of a write to 0x20 -> outputs 0, BUSY=0, mem[8] unchanged; next read completes normally.
- CE held high across READY with RD=1 -> second read accepted in the IDLE cycle after DONE, two READY pulses exactly WAIT_CYCLES+3 cycles apart.

Source files
------------

// File: rtl/data_ram_responder.sv
// Word-addressed data RAM slave for the CPU RAM port: latches a request, waits
// WAIT_CYCLES, performs read/write/swap, and returns a one-cycle READY pulse.
module data_ram_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRAM_CE,
  input  logic        iRAM_RD,
  input  logic        iRAM_WR,
  input  logic [7:0]  iRAM_ADDR,
  input  logic [31:0] iRAM_DATA,
  output logic [31:0] oRAM_DATA,
  output logic        oRAM_READY,
  output logic        oRAM_ERR,
  output logic        oRAM_BUSY,
  input  logic [5:0]  iDBG_ADDR,
  output logic [31:0] oDBG_DATA
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        addr_q;
  logic [31:0]       wdata_q;
  logic              rd_q, wr_q;
  logic [31:0]       data_q, data_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              req_c, latch_c, we_c, bad_c;
  logic [5:0]        idx_c;
  logic [31:0]       mem_q [DEPTH];

  assign req_c = iRAM_CE & (iRAM_RD | iRAM_WR);
  assign idx_c = addr_q[7:2];
  // Out-of-range indices are errors, never aliased onto smaller arrays.
  assign bad_c = (addr_q[1:0] != 2'b00) || (32'(idx_c) >= DEPTH);

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          cnt_d = '0;
          if (WAIT_CYCLES == 0) state_d = S_ACCESS;
          else                  state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) state_d = S_ACCESS;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; response fields are zero outside DONE
  always_comb begin
    data_d  = '0;
    ready_d = 1'b0;
    err_d   = 1'b0;
    we_c    = 1'b0;
    latch_c = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: latch_c = req_c;
      S_ACCESS: begin
        ready_d = 1'b1;
        if (bad_c) begin
          err_d = 1'b1;
        end else begin
          if (rd_q) data_d = mem_q[IDX_W'(idx_c)];
          we_c = wr_q;
        end
      end
      default: ;
    endcase
  end

  // Request latch and registered outputs
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (latch_c) begin
        addr_q  <= iRAM_ADDR;
        wdata_q <= iRAM_DATA;
        rd_q    <= iRAM_RD;
        wr_q    <= iRAM_WR;
      end
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is deliberately not reset; a swap reads the old word on the same edge
  always_ff @(posedge iCLK) begin
    if (we_c) mem_q[IDX_W'(idx_c)] <= wdata_q;
  end

  always_comb begin
    oDBG_DATA = '0;
    if (32'(iDBG_ADDR) < DEPTH) oDBG_DATA = mem_q[IDX_W'(iDBG_ADDR)];
  end

  assign oRAM_DATA  = data_q;
  assign oRAM_READY = ready_q;
  assign oRAM_ERR   = err_q;
  assign oRAM_BUSY  = busy_q;

endmodule
